// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline freeze/flush sequencer.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 4;
  localparam logic [REG_W-1:0] R0 = '0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DSTALL = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  typedef struct packed {
    logic pc_freeze;
    logic pc_src;
    logic if_id_freeze;
    logic if_id_flush;
    logic id_ex_freeze;
    logic id_ex_flush;
    logic ex_mem_freeze;
    logic mem_wb_freeze;
    logic icache_abort;
    logic hlt;
  } ctrl_t;

  // PC and every stage register held; no flushes, no redirect.
  function automatic ctrl_t freeze_all();
    ctrl_t c;
    c               = '0;
    c.pc_freeze     = 1'b1;
    c.if_id_freeze  = 1'b1;
    c.id_ex_freeze  = 1'b1;
    c.ex_mem_freeze = 1'b1;
    c.mem_wb_freeze = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs, stage control outputs and performance counters of the sequencer.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import pipeline_hazard_ctrl_pkg::*;

  logic             id_ex_memread;
  logic [REG_W-1:0] id_ex_rd;
  logic [REG_W-1:0] if_id_rs;
  logic [REG_W-1:0] if_id_rt;
  logic             if_id_uses_rt;
  logic             branch_taken;
  logic             icache_miss;
  logic             dcache_miss;
  logic             wb_halt;

  logic             pc_freeze;
  logic             pc_src;
  logic             if_id_freeze;
  logic             if_id_flush;
  logic             id_ex_freeze;
  logic             id_ex_flush;
  logic             ex_mem_freeze;
  logic             mem_wb_freeze;
  logic             icache_abort;
  logic             hlt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Controller side.
  modport master (
    input  id_ex_memread, id_ex_rd, if_id_rs, if_id_rt, if_id_uses_rt,
           branch_taken, icache_miss, dcache_miss, wb_halt,
    output pc_freeze, pc_src, if_id_freeze, if_id_flush, id_ex_freeze,
           id_ex_flush, ex_mem_freeze, mem_wb_freeze, icache_abort, hlt,
           stall_cnt, flush_cnt
  );

  // Pipeline side.
  modport slave (
    output id_ex_memread, id_ex_rd, if_id_rs, if_id_rt, if_id_uses_rt,
           branch_taken, icache_miss, dcache_miss, wb_halt,
    input  pc_freeze, pc_src, if_id_freeze, if_id_flush, id_ex_freeze,
           id_ex_flush, ex_mem_freeze, mem_wb_freeze, icache_abort, hlt,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central freeze/flush sequencer for the 5-stage pipeline; controls act in the same cycle.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.master hz
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_c;
  logic   run_eval_c;
  logic   load_use_c;

  assign load_use_c = hz.id_ex_memread && (hz.id_ex_rd != R0) &&
                      ((hz.id_ex_rd == hz.if_id_rs) ||
                       (hz.if_id_uses_rt && (hz.id_ex_rd == hz.if_id_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // DSTALL releases in the same cycle dcache_miss drops, then falls into RUN priority.
  always_comb begin
    ctrl_c     = '0;
    state_d    = state_q;
    run_eval_c = 1'b0;
    if (rst) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_HALTED: begin
          ctrl_c     = freeze_all();
          ctrl_c.hlt = 1'b1;
        end
        ST_DSTALL: begin
          if (hz.dcache_miss) begin
            ctrl_c = freeze_all();
          end else begin
            state_d    = ST_RUN;
            run_eval_c = 1'b1;
          end
        end
        default: run_eval_c = 1'b1;
      endcase

      if (run_eval_c) begin
        if (hz.wb_halt) begin
          ctrl_c  = freeze_all();
          state_d = ST_HALTED;
        end else if (hz.dcache_miss) begin
          ctrl_c  = freeze_all();
          state_d = ST_DSTALL;
        end else if (load_use_c) begin
          ctrl_c.pc_freeze    = 1'b1;
          ctrl_c.if_id_freeze = 1'b1;
          ctrl_c.id_ex_flush  = 1'b1;
        end else if (hz.branch_taken) begin
          ctrl_c.pc_src       = 1'b1;
          ctrl_c.if_id_flush  = 1'b1;
          ctrl_c.icache_abort = hz.icache_miss;
        end else if (hz.icache_miss) begin
          ctrl_c.pc_freeze   = 1'b1;
          ctrl_c.if_id_flush = 1'b1;
        end
      end
    end
  end

  assign hz.pc_freeze     = ctrl_c.pc_freeze;
  assign hz.pc_src        = ctrl_c.pc_src;
  assign hz.if_id_freeze  = ctrl_c.if_id_freeze;
  assign hz.if_id_flush   = ctrl_c.if_id_flush;
  assign hz.id_ex_freeze  = ctrl_c.id_ex_freeze;
  assign hz.id_ex_flush   = ctrl_c.id_ex_flush;
  assign hz.ex_mem_freeze = ctrl_c.ex_mem_freeze;
  assign hz.mem_wb_freeze = ctrl_c.mem_wb_freeze;
  assign hz.icache_abort  = ctrl_c.icache_abort;
  assign hz.hlt           = ctrl_c.hlt;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl_c.pc_freeze),
    .cnt (hz.stall_cnt)
  );

  // Every redirect is a taken-branch flush of IF_ID.
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl_c.pc_src),
    .cnt (hz.flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a rule-level model checked every cycle.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       memread, uses_rt, branch, imiss, dmiss, halt;
  logic [3:0] rd, rs, rt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hz16 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  hz4 ();

  assign hz16.id_ex_memread = memread;
  assign hz16.id_ex_rd      = rd;
  assign hz16.if_id_rs      = rs;
  assign hz16.if_id_rt      = rt;
  assign hz16.if_id_uses_rt = uses_rt;
  assign hz16.branch_taken  = branch;
  assign hz16.icache_miss   = imiss;
  assign hz16.dcache_miss   = dmiss;
  assign hz16.wb_halt       = halt;
  assign hz4.id_ex_memread  = memread;
  assign hz4.id_ex_rd       = rd;
  assign hz4.if_id_rs       = rs;
  assign hz4.if_id_rt       = rt;
  assign hz4.if_id_uses_rt  = uses_rt;
  assign hz4.branch_taken   = branch;
  assign hz4.icache_miss    = imiss;
  assign hz4.dcache_miss    = dmiss;
  assign hz4.wb_halt        = halt;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .hz(hz16.master));
  pipeline_hazard_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .hz(hz4.master));

  // Bit order: pc_freeze, pc_src, if_id_freeze, if_id_flush, id_ex_freeze,
  // id_ex_flush, ex_mem_freeze, mem_wb_freeze, icache_abort, hlt.
  logic [9:0] act16, act4;
  assign act16 = {hz16.pc_freeze, hz16.pc_src, hz16.if_id_freeze, hz16.if_id_flush,
                  hz16.id_ex_freeze, hz16.id_ex_flush, hz16.ex_mem_freeze,
                  hz16.mem_wb_freeze, hz16.icache_abort, hz16.hlt};
  assign act4  = {hz4.pc_freeze, hz4.pc_src, hz4.if_id_freeze, hz4.if_id_flush,
                  hz4.id_ex_freeze, hz4.id_ex_flush, hz4.ex_mem_freeze,
                  hz4.mem_wb_freeze, hz4.icache_abort, hz4.hlt};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: halted, or parked on a D-miss (which then ignores wb_halt).
  bit m_halted = 1'b0;
  bit m_dstall = 1'b0;
  bit started  = 1'b0;
  int m_stall16, m_flush16, m_stall4, m_flush4;

  always @(negedge clk) begin
    logic lu, frz, nrm;
    logic [9:0] exp;
    lu  = memread && (rd != 4'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
    frz = m_halted || halt || dmiss;
    nrm = !frz;
    exp = {frz || (nrm && (lu || (!branch && imiss))),
           nrm && !lu && branch,
           frz || (nrm && lu),
           nrm && !lu && (branch || imiss),
           frz,
           nrm && lu,
           frz,
           frz,
           nrm && !lu && branch && imiss,
           m_halted};
    if (rst) exp = '0;

    if (started) begin
      check("ctrl16", 32'(act16), 32'(exp));
      check("ctrl4", 32'(act4), 32'(exp));
      check("stall_cnt16", 32'(hz16.stall_cnt), 32'(m_stall16));
      check("flush_cnt16", 32'(hz16.flush_cnt), 32'(m_flush16));
      check("stall_cnt4", 32'(hz4.stall_cnt), 32'(m_stall4));
      check("flush_cnt4", 32'(hz4.flush_cnt), 32'(m_flush4));
    end

    if (rst) begin
      m_halted  = 1'b0;
      m_dstall  = 1'b0;
      m_stall16 = 0; m_flush16 = 0; m_stall4 = 0; m_flush4 = 0;
      started   = 1'b1;
    end else begin
      if (exp[9] && m_stall16 < 65535) m_stall16++;
      if (exp[8] && m_flush16 < 65535) m_flush16++;
      if (exp[9] && m_stall4 < 15) m_stall4++;
      if (exp[8] && m_flush4 < 15) m_flush4++;
      begin
        bit nh, nd;
        nh = m_halted || (halt && !(m_dstall && dmiss));
        nd = !m_halted && dmiss && (m_dstall || !halt);
        m_halted = nh;
        m_dstall = nd;
      end
    end
  end

  task automatic clr();
    memread = 0; uses_rt = 0; branch = 0; imiss = 0; dmiss = 0; halt = 0;
    rd = 0; rs = 0; rt = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    @(negedge clk);
    next();
    rst = 1'b0;
  endtask

  initial begin
    clr();
    rst   = 1'b1;
    dmiss = 1'b1;
    halt  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset_ctrl", 32'(act16), 32'h0);
      next();
    end
    check("reset_stall", 32'(hz16.stall_cnt), 32'd0);
    check("reset_flush", 32'(hz16.flush_cnt), 32'd0);
    rst = 1'b0;
    clr();
    @(negedge clk);
    check("run_idle", 32'(act16), 32'h0);
    next();

    // Load-use on rs, branch ignored.
    memread = 1; rd = 4'd3; rs = 4'd3; branch = 1;
    @(negedge clk);
    check("lu_ctrl", 32'(act16), 32'(10'b1010010000));
    next();
    check("lu_stall", 32'(hz16.stall_cnt), 32'd1);
    check("lu_flush", 32'(hz16.flush_cnt), 32'd0);
    rd = 4'd0; rs = 4'd0; branch = 0;
    @(negedge clk);
    check("lu_r0", 32'(act16), 32'h0);
    next();
    memread = 1; rd = 4'd5; rs = 4'd1; rt = 4'd5; uses_rt = 1;
    @(negedge clk);
    check("lu_rt", 32'(act16), 32'(10'b1010010000));
    next();
    uses_rt = 0;
    @(negedge clk);
    check("lu_rt_unused", 32'(act16), 32'h0);
    next();
    check("lu_stall2", 32'(hz16.stall_cnt), 32'd2);

    // Branch during I-miss, then I-miss alone.
    do_reset();
    branch = 1; imiss = 1;
    @(negedge clk);
    check("br_imiss", 32'(act16), 32'(10'b0101000010));
    next();
    check("br_flush", 32'(hz16.flush_cnt), 32'd1);
    check("br_stall", 32'(hz16.stall_cnt), 32'd0);
    branch = 0;
    @(negedge clk);
    check("imiss_only", 32'(act16), 32'(10'b1001000000));
    next();

    // D-miss for four cycles, zero-cycle release.
    do_reset();
    dmiss = 1;
    repeat (4) begin
      @(negedge clk);
      check("dmiss_ctrl", 32'(act16), 32'(10'b1010101100));
      next();
    end
    dmiss = 0;
    @(negedge clk);
    check("dmiss_release", 32'(act16), 32'h0);
    check("dmiss_stall", 32'(hz16.stall_cnt), 32'd4);
    next();
    dmiss = 1;
    next();
    dmiss = 0; memread = 1; rd = 4'd2; rs = 4'd2;
    @(negedge clk);
    check("dmiss_then_lu", 32'(act16), 32'(10'b1010010000));
    next();

    // Halt then random traffic.
    do_reset();
    halt = 1;
    @(negedge clk);
    check("halt_entry", 32'(act16), 32'(10'b1010101100));
    next();
    repeat (10) begin
      memread = 1'($urandom_range(0, 1));
      uses_rt = 1'($urandom_range(0, 1));
      branch  = 1'($urandom_range(0, 1));
      imiss   = 1'($urandom_range(0, 1));
      dmiss   = 1'($urandom_range(0, 1));
      halt    = 1'($urandom_range(0, 1));
      rd      = 4'($urandom_range(0, 15));
      rs      = 4'($urandom_range(0, 15));
      rt      = 4'($urandom_range(0, 15));
      @(negedge clk);
      check("halted_ctrl", 32'(act16), 32'(10'b1010101101));
      next();
    end
    check("halt_stall", 32'(hz16.stall_cnt), 32'd11);
    clr();
    rst = 1'b1;
    @(negedge clk);
    check("halt_rst", 32'(act16), 32'h0);
    next();
    rst = 1'b0;
    @(negedge clk);
    check("halt_cleared", 32'(hz16.hlt), 32'd0);
    next();

    // Counter saturation on the narrow instance.
    do_reset();
    imiss = 1;
    repeat (20) next();
    check("sat_stall4", 32'(hz4.stall_cnt), 32'd15);
    check("sat_stall16", 32'(hz16.stall_cnt), 32'd20);
    clr();
    next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central freeze/flush sequencer for the 5-stage 16-bit pipeline (IF, ID, EX, MEM, WB).
- Drives the freeze/flush inputs of IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, plus the PC freeze and PC-source select.
- Resolves load-use hazards, taken-branch redirects, I-cache and D-cache miss stalls, and HLT retirement.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- REG_W, 4, register-specifier width (16 GPRs, R0 hardwired zero).
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_ex_memread  in  1  instruction in EX is a load.
- id_ex_rd  in  REG_W  destination register of the instruction in EX.
- if_id_rs  in  REG_W  source 1 of the instruction in ID.
- if_id_rt  in  REG_W  source 2 of the instruction in ID.
- if_id_uses_rt  in  1  ID instruction reads rt.
- branch_taken  in  1  ID-stage branch resolved taken.
- icache_miss  in  1  fetch not yet returned.
- dcache_miss  in  1  MEM access not yet complete.
- wb_halt  in  1  HLT instruction is in WB.
- pc_freeze  out  1  hold PC.
- pc_src  out  1  1 = load branch target into PC.
- if_id_freeze, if_id_flush  out  1 each.
- id_ex_freeze, id_ex_flush  out  1 each.
- ex_mem_freeze, mem_wb_freeze  out  1 each.
- icache_abort  out  1  cancel outstanding fetch.
- hlt  out  1  processor halted.
- stall_cnt  out  CNT_W  cycles with pc_freeze=1.
- flush_cnt  out  CNT_W  taken-branch flushes.

Behaviour:
- Registered state: STATE in {RUN, DSTALL, HALTED}, plus stall_cnt and flush_cnt.
- All control outputs are combinational from state and current inputs, so they act at the same clock edge.
- Reset: while rst=1, all control outputs are 0. Next state is RUN; counters clear to 0. Reset wins over every input, including in DSTALL or HALTED.
- Priority in RUN, highest first:
  1. wb_halt.
  2. dcache_miss.
  3. load-use.
  4. branch_taken.
  5. icache_miss.
- wb_halt: go to HALTED next cycle. In the current cycle all freezes are 1 and hlt=0.
- HALTED: all freezes 1, all flushes 0, hlt=1, pc_src=0. Leave only on rst.
- dcache_miss=1: pc_freeze and all four stage freezes are 1, flushes 0, pc_src=0. Go to DSTALL.
- DSTALL: same freezes while dcache_miss=1. When dcache_miss=0, return to RUN in that cycle with no freeze (zero-cycle release). Any pending load-use or branch is then evaluated normally.
- Load-use condition: id_ex_memread AND id_ex_rd != 0 AND (id_ex_rd == if_id_rs OR (if_id_uses_rt AND id_ex_rd == if_id_rt)).
  - Response: pc_freeze=1, if_id_freeze=1, id_ex_flush=1 for exactly one cycle. The condition self-clears as the load advances.
  - branch_taken is ignored in a load-use cycle, because operands are stale.
- branch_taken (no load-use): pc_src=1, if_id_flush=1, flush_cnt increments; single cycle.
  - If icache_miss is also 1: icache_abort=1 and pc_freeze=0, so the redirect wins.
- icache_miss alone: pc_freeze=1, if_id_flush=1 (bubble into ID); later stages proceed.
- Freeze and flush are never both asserted on the same register.
- stall_cnt increments on every cycle with pc_freeze=1, including HALTED. flush_cnt increments on each branch flush. Both saturate at 2^CNT_W-1 with no wrap.

Decomposition:
- Shared package: state encoding (RUN=2'b00, DSTALL=2'b01, HALTED=2'b10), REG_W, and the R0 constant.
- Sub-module sat_counter (CNT_W, inc, clk, rst), instantiated twice for stall_cnt and flush_cnt.
- Hazard priority logic stays in the top block.

Test Plan:
- Reset: rst=1 for 2 cycles with dcache_miss=1 and wb_halt=1. All outputs are 0 and counters are 0. After release with inputs low, state is RUN.
- Load-use: id_ex_memread=1, id_ex_rd=3, if_id_rs=3, branch_taken=1. For one cycle pc_freeze=1, if_id_freeze=1, id_ex_flush=1, pc_src=0; stall_cnt=1. Repeat with id_ex_rd=0: no stall.
- Branch during I-miss: branch_taken=1 and icache_miss=1 for one cycle. pc_src=1, if_id_flush=1, icache_abort=1, pc_freeze=0; flush_cnt=1.
- D-miss stall: dcache_miss=1 for 4 cycles, then 0. All freezes are 1 for exactly 4 cycles, stall_cnt=4, and the fifth cycle has no freezes.
- Halt: wb_halt=1 for one cycle, then random inputs for 10 cycles. hlt=1 from the next cycle, all freezes stay 1, stall_cnt=11, pc_src is never 1. Then rst=1 clears hlt.
- Saturation: CNT_W=4 with 20 consecutive I-miss cycles. stall_cnt holds at 15.
